// File: rtl/alu_result_stage.sv
// ALU result stage: classifies each ALU result (illegal opcode, divide-by-zero, flags)
// and queues it in a 2-entry in-order FIFO with a saturating error counter.
module alu_result_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [63:0] value_b,
    input  logic [64:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [3:0]  out_opcode,
    output logic [4:0]  flags,
    input  logic        err_clr,
    output logic [15:0] err_cnt
);

    // Entry layout: [72:69] opcode, [68:64] flags {illegal, div_zero, carry, negative, zero}, [63:0] result
    localparam int ENTRY_W = 73;

    function automatic logic [ENTRY_W-1:0] build_entry(
        input logic [3:0]  op,
        input logic [63:0] b,
        input logic [64:0] yv
    );
        logic        illegal;
        logic        div_zero;
        logic        bad;
        logic [63:0] res;
        logic        carry;
        illegal  = (op == 4'b0101) || (op >= 4'b1010);
        div_zero = ((op == 4'b0011) || (op == 4'b0100)) && (b == 64'd0);
        bad      = illegal | div_zero;
        res      = bad ? 64'd0 : yv[63:0];
        carry    = bad ? 1'b0 : yv[64];
        return {op, illegal, div_zero, carry, res[63], (res == 64'd0), res};
    endfunction

    function automatic logic entry_is_error(input logic [ENTRY_W-1:0] e);
        return e[68] | e[67];
    endfunction

    logic [1:0]         count_r;
    logic [1:0]         count_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] head_s;
    logic [ENTRY_W-1:0] tail_r;
    logic [ENTRY_W-1:0] tail_s;
    logic [ENTRY_W-1:0] new_s;
    logic               out_valid_r;
    logic               full_r;
    logic [15:0]        err_cnt_r;
    logic               push_s;
    logic               pop_s;

    // Gating with rst_n keeps in_ready low during reset yet high right after release
    assign in_ready   = rst_n & ~full_r;
    assign out_valid  = out_valid_r;
    assign result     = head_r[63:0];
    assign flags      = head_r[68:64];
    assign out_opcode = head_r[72:69];
    assign err_cnt    = err_cnt_r;

    // Next-state FIFO contents; head is zeroed whenever the FIFO drains so outputs read 0 when empty
    always_comb begin
        push_s  = in_valid & in_ready;
        pop_s   = out_valid_r & out_ready;
        new_s   = build_entry(opcode, value_b, y);
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_s  = new_s;
                    count_s = 2'd1;
                end else begin
                    count_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_s = new_s;
                end else if (push_s) begin
                    tail_s  = new_s;
                    count_s = 2'd2;
                end else if (pop_s) begin
                    head_s  = '0;
                    count_s = 2'd0;
                end else begin
                    count_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_s  = tail_r;
                    tail_s  = '0;
                    count_s = 2'd1;
                end else begin
                    count_s = 2'd2;
                end
            end
            default: begin
                head_s  = '0;
                tail_s  = '0;
                count_s = 2'd0;
            end
        endcase
    end

    // FIFO state and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            head_r      <= '0;
            tail_r      <= '0;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            count_r     <= count_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            out_valid_r <= (count_s != 2'd0);
            full_r      <= (count_s == 2'd2);
        end
    end

    // Saturating error counter; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 16'd0;
        end else if (err_clr) begin
            err_cnt_r <= 16'd0;
        end else if (push_s && entry_is_error(new_s) && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// directed cases with literal expectations, randomized traffic, saturation and reset.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [63:0] value_b = 64'd0;
    logic [64:0] y = 65'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic [3:0]  out_opcode;
    logic [4:0]  flags;
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .value_b(value_b), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_opcode(out_opcode),
        .flags(flags), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  fl;
        logic [63:0] res;
    } exp_t;

    exp_t        q[$];
    int unsigned m_err = 0;
    int          errors = 0;
    int          checks = 0;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_DIV = 4'b0011, OP_MOD = 4'b0100;

    function automatic exp_t make_exp(input logic [3:0] op, input logic [63:0] vb, input logic [64:0] yv);
        exp_t e;
        bit   ill, dz, c;
        ill = (op == 4'd5) || (op > 4'd9);
        dz  = ((op == 4'd3) || (op == 4'd4)) && (vb == 64'd0);
        e.op = op;
        if (ill || dz) begin
            e.res = 64'd0;
            c = 1'b0;
        end else begin
            e.res = yv[63:0];
            c = yv[64];
        end
        e.fl = {ill, dz, c, e.res[63], e.res == 64'd0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        exp_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("result", result, h.res);
        chk("out_opcode", 64'(out_opcode), 64'(h.op));
        chk("flags", 64'(flags), 64'(h.fl));
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check at the falling edge
    task automatic step(input logic iv, input logic [3:0] op, input logic [63:0] vb,
                        input logic [64:0] yv, input logic ordy, input logic clr);
        bit   do_push, do_pop;
        exp_t e;
        in_valid = iv; opcode = op; value_b = vb; y = yv; out_ready = ordy; err_clr = clr;
        do_push = iv && (q.size() < 2);
        do_pop  = (q.size() > 0) && ordy;
        e = make_exp(op, vb, yv);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (clr) m_err = 0;
        else if (do_push && (e.fl[4] || e.fl[3]) && m_err < 65535) m_err++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        step(1'b0, OP_ADD, 64'd0, 65'd0, 1'b1, 1'b0);
        step(1'b0, OP_ADD, 64'd0, 65'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [64:0] ry;
        logic [63:0] rb;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        #11 rst_n = 1'b1;
        #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        compare_all();

        // ADD 1 + 16
        step(1'b1, OP_ADD, 64'd16, 65'd17, 1'b0, 1'b0);
        chk("add_model", q[0].res, 64'h11);
        chk("add_result", result, 64'h11);
        chk("add_flags", 64'(flags), 64'd0);
        chk("add_valid", 64'(out_valid), 64'd1);
        drain();

        // DIV and MOD by zero
        step(1'b1, OP_DIV, 64'd0, 65'h1_2345_6789_ABCD_EF01, 1'b1, 1'b0);
        chk("div0_result", result, 64'd0);
        chk("div0_flags", 64'(flags), 64'(5'b01001));
        chk("div0_err", 64'(err_cnt), 64'd1);
        step(1'b1, OP_MOD, 64'd0, 65'd99, 1'b1, 1'b0);
        chk("mod0_err", 64'(err_cnt), 64'd2);
        chk("mod0_flags", 64'(flags), 64'(5'b01001));

        // Illegal opcode, then clear coincident with another illegal push
        step(1'b1, 4'b0101, 64'd7, 65'h1_0000_0000_0000_0005, 1'b1, 1'b0);
        chk("ill_result", result, 64'd0);
        chk("ill_flags", 64'(flags), 64'(5'b10001));
        chk("ill_err", 64'(err_cnt), 64'd3);
        step(1'b1, 4'b1100, 64'd1, 65'd4, 1'b1, 1'b1);
        chk("clr_err", 64'(err_cnt), 64'd0);
        drain();

        // SUB negative, then carry with zero result
        step(1'b1, OP_SUB, 64'd1, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        chk("sub_neg_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_neg_flags", 64'(flags), 64'(5'b00010));
        step(1'b1, OP_SUB, 64'd1, 65'h1_0000_0000_0000_0000, 1'b1, 1'b0);
        chk("sub_cz_flags", 64'(flags), 64'(5'b00101));
        drain();

        // Backpressure: three pushes with consumer stalled, then ordered pops
        step(1'b1, OP_ADD, 64'd0, 65'd1, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 64'd0, 65'd2, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, OP_ADD, 64'd0, 65'd3, 1'b0, 1'b0);
        chk("held_head", result, 64'd1);
        step(1'b1, OP_ADD, 64'd0, 65'd3, 1'b1, 1'b0);
        chk("pop2", result, 64'd2);
        step(1'b1, OP_ADD, 64'd0, 65'd3, 1'b1, 1'b0);
        chk("pop3", result, 64'd3);
        drain();
        chk("drained", 64'(out_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ry[31:0]  = $urandom();
            ry[63:32] = $urandom();
            ry[64]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rb = 64'd0;
            else rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ry[63:0] = 64'd0;
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rb, ry,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        // Error counter saturation
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 4'b1111, 64'd1, 65'd5, 1'b1, 1'b0);
        end
        chk("sat_err", 64'(err_cnt), 64'hFFFF);
        step(1'b1, 4'b1111, 64'd1, 65'd5, 1'b1, 1'b1);
        chk("sat_clr", 64'(err_cnt), 64'd0);

        // Mid-cycle reset with two entries stored
        step(1'b1, 4'b1010, 64'd1, 65'd8, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 64'd1, 65'd9, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_flags", 64'(flags), 64'd0);
        q.delete();
        m_err = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("arel_in_ready", 64'(in_ready), 64'd1);
        chk("arel_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        compare_all();
        step(1'b1, OP_ADD, 64'd3, 65'd42, 1'b1, 1'b0);
        chk("post_rst_result", result, 64'd42);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
